// File: rtl/riscv5_pkg.sv
// Shared definitions for the riscv5 data-memory responder: MMIO map, status bits,
// serializer states and the byte-lane merge helper.
package riscv5_pkg;

  localparam logic [31:0] MMIO_BASE   = 32'h8000_0000;
  // Word offsets within the MMIO page, as decoded from addr[4:2]
  localparam logic [2:0]  OFF_GPIO    = 3'd0;
  localparam logic [2:0]  OFF_TIMER   = 3'd1;
  localparam logic [2:0]  OFF_TIMECMP = 3'd2;
  localparam logic [2:0]  OFF_TXDATA  = 3'd3;
  localparam logic [2:0]  OFF_STATUS  = 3'd4;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
      else         res[8*i +: 8] = old_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/riscv5_uart_tx.sv
// TX FIFO plus 8N1 serializer; a frame restarts straight from STOP when more
// bytes are queued so bursts leave the line with no idle gap.
module riscv5_uart_tx
  import riscv5_pkg::*;
#(
  parameter int BAUD_DIV = 868,
  parameter int FIFO_AW  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       clr_ovf,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       overflow,
  output logic       tx
);

  localparam int              BW        = $clog2(BAUD_DIV);
  localparam logic [BW-1:0]   BAUD_LAST = BW'(BAUD_DIV - 1);

  logic [7:0]         fifo_q [2**FIFO_AW];
  logic [FIFO_AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic               ovf_q, ovf_d;
  uart_state_e        state_q, state_d;
  logic [BW-1:0]      baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic               do_push_s, do_pop_s, baud_done_s;

  assign full        = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                       (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
  assign empty       = (wptr_q == rptr_q);
  assign busy        = (state_q != UART_IDLE);
  assign overflow    = ovf_q;
  assign tx          = tx_q;
  assign baud_done_s = (baud_q == BAUD_LAST);
  assign do_push_s   = push && !full;

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    do_pop_s = 1'b0;
    case (state_q)
      UART_IDLE: begin
        if (!empty) begin
          do_pop_s = 1'b1;
          shift_d  = fifo_q[rptr_q[FIFO_AW-1:0]];
          state_d  = UART_START;
        end else begin
          state_d  = UART_IDLE;
        end
      end
      UART_START: begin
        if (baud_done_s) begin
          state_d = UART_DATA;
          bit_d   = 3'd0;
        end else begin
          state_d = UART_START;
        end
      end
      UART_DATA: begin
        if (baud_done_s && bit_q == 3'd7) begin
          state_d = UART_STOP;
        end else if (baud_done_s) begin
          bit_d   = bit_q + 3'd1;
          shift_d = {1'b0, shift_q[7:1]};
        end else begin
          state_d = UART_DATA;
        end
      end
      UART_STOP: begin
        if (baud_done_s && !empty) begin
          do_pop_s = 1'b1;
          shift_d  = fifo_q[rptr_q[FIFO_AW-1:0]];
          state_d  = UART_START;
        end else if (baud_done_s) begin
          state_d  = UART_IDLE;
        end else begin
          state_d  = UART_STOP;
        end
      end
      default: state_d = UART_IDLE;
    endcase

    if (state_q == UART_IDLE || baud_done_s) baud_d = '0;
    else                                     baud_d = baud_q + BW'(1);

    // Line level is taken from the next state so it lands one cycle after the pop edge
    case (state_d)
      UART_START: tx_d = 1'b0;
      UART_DATA:  tx_d = shift_d[0];
      default:    tx_d = 1'b1;
    endcase

    if (push && full) ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
    else              ovf_d = ovf_q;

    wptr_d = wptr_q + {{FIFO_AW{1'b0}}, do_push_s};
    rptr_d = rptr_q + {{FIFO_AW{1'b0}}, do_pop_s};
  end

  always_ff @(posedge clk) begin
    if (do_push_s) fifo_q[wptr_q[FIFO_AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      ovf_q   <= 1'b0;
      state_q <= UART_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/riscv5_dmem_resp.sv
// dmem target for the riscv5 pipeline: byte-strobed word RAM below 0x8000_0000 and an
// MMIO page with GPIO, timer/compare and UART TX above it. Reads are combinational.
module riscv5_dmem_resp
  import riscv5_pkg::*;
#(
  parameter int RAM_AW   = 10,
  parameter int BAUD_DIV = 868,
  parameter int FIFO_AW  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmem_we,
  input  logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic [31:0] gpio_out,
  output logic        timer_irq,
  output logic        uart_tx
);

  logic [31:0]       ram_q [2**RAM_AW];
  logic [RAM_AW-1:0] ram_idx_s;
  logic              sel_mmio_s, mmio_we_s;
  logic [2:0]        mmio_off_s;
  logic [31:0]       gpio_q, gpio_d, timer_q, timer_d, timecmp_q, timecmp_d;
  logic              push_s, clr_ovf_s, full_s, empty_s, busy_s, ovf_s;
  logic [31:0]       status_s;
  logic              addr_unused_s;

  assign ram_idx_s     = dmem_addr[RAM_AW+1:2];
  assign sel_mmio_s    = dmem_addr[31];
  assign mmio_off_s    = dmem_addr[4:2];
  assign mmio_we_s     = dmem_we && sel_mmio_s;
  assign addr_unused_s = ^{dmem_addr[30:RAM_AW+2], dmem_addr[1:0]};

  assign push_s    = mmio_we_s && (mmio_off_s == OFF_TXDATA) && dmem_wstrb[0];
  assign clr_ovf_s = mmio_we_s && (mmio_off_s == OFF_STATUS) && dmem_wstrb[0] && dmem_wdata[ST_OVF];

  assign status_s  = {28'h0, ovf_s, busy_s, empty_s, full_s};
  assign gpio_out  = gpio_q;
  assign timer_irq = (timer_q >= timecmp_q);

  always_comb begin
    gpio_d    = gpio_q;
    timecmp_d = timecmp_q;
    timer_d   = timer_q + 32'd1;
    // A strobeless write is a no-op, so the timer keeps counting through it
    if (mmio_we_s && (dmem_wstrb != 4'h0)) begin
      case (mmio_off_s)
        OFF_GPIO:    gpio_d    = apply_wstrb(gpio_q, dmem_wdata, dmem_wstrb);
        OFF_TIMER:   timer_d   = apply_wstrb(timer_q, dmem_wdata, dmem_wstrb);
        OFF_TIMECMP: timecmp_d = apply_wstrb(timecmp_q, dmem_wdata, dmem_wstrb);
        default:     gpio_d    = gpio_q;
      endcase
    end else begin
      gpio_d = gpio_q;
    end
  end

  always_comb begin
    dmem_rdata = 32'h0000_0000;
    if (!sel_mmio_s) begin
      dmem_rdata = ram_q[ram_idx_s];
    end else begin
      case (mmio_off_s)
        OFF_GPIO:    dmem_rdata = gpio_q;
        OFF_TIMER:   dmem_rdata = timer_q;
        OFF_TIMECMP: dmem_rdata = timecmp_q;
        OFF_STATUS:  dmem_rdata = status_s;
        default:     dmem_rdata = 32'h0000_0000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (dmem_we && !sel_mmio_s) begin
      for (int i = 0; i < 4; i++) begin
        if (dmem_wstrb[i]) ram_q[ram_idx_s][8*i +: 8] <= dmem_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpio_q    <= 32'h0000_0000;
      timer_q   <= 32'h0000_0000;
      timecmp_q <= 32'hFFFF_FFFF;
    end else begin
      gpio_q    <= gpio_d;
      timer_q   <= timer_d;
      timecmp_q <= timecmp_d;
    end
  end

  riscv5_uart_tx #(
    .BAUD_DIV (BAUD_DIV),
    .FIFO_AW  (FIFO_AW)
  ) u_uart_tx (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (dmem_wdata[7:0]),
    .clr_ovf   (clr_ovf_s),
    .full      (full_s),
    .empty     (empty_s),
    .busy      (busy_s),
    .overflow  (ovf_s),
    .tx        (uart_tx)
  );

endmodule

// File: tb/tb_riscv5_dmem_resp.sv
// Self-checking bench for riscv5_dmem_resp; UART bytes are scoreboarded through a
// queue and decoded from uart_tx by a free-running monitor.
module tb_riscv5_dmem_resp;

  localparam int          BAUD      = 4;
  localparam logic [31:0] A_GPIO    = 32'h8000_0000;
  localparam logic [31:0] A_TIMER   = 32'h8000_0004;
  localparam logic [31:0] A_TIMECMP = 32'h8000_0008;
  localparam logic [31:0] A_TXDATA  = 32'h8000_000C;
  localparam logic [31:0] A_STATUS  = 32'h8000_0010;
  localparam logic [31:0] A_UNMAP   = 32'h8000_0018;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dmem_we = 1'b0;
  logic [3:0]  dmem_wstrb = 4'h0;
  logic [31:0] dmem_addr = 32'h0;
  logic [31:0] dmem_wdata = 32'h0;
  logic [31:0] dmem_rdata, gpio_out;
  logic        timer_irq, uart_tx;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  bit          mon_en = 1'b1;
  logic [7:0]  exp_q[$];
  int          frame_starts[$];

  riscv5_dmem_resp #(.RAM_AW(10), .BAUD_DIV(BAUD), .FIFO_AW(3)) dut (
    .clk(clk), .rst(rst), .dmem_we(dmem_we), .dmem_wstrb(dmem_wstrb),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .gpio_out(gpio_out), .timer_irq(timer_irq), .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

  // Frame decoder: samples each bit in its middle, compares against the scoreboard
  initial begin : uart_mon
    logic [7:0] b;
    logic [7:0] e;
    int st;
    forever begin
      @(negedge clk);
      if (mon_en && !rst && uart_tx === 1'b0) begin
        st = cyc;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BAUD) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (BAUD) @(negedge clk);
        n_vec++;
        if (uart_tx !== 1'b1) begin n_err++; $display("FAIL uart_stop got %b want 1", uart_tx); end
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL uart_byte got %h want no frame", b);
        end else begin
          e = exp_q.pop_front();
          if (b !== e) begin n_err++; $display("FAIL uart_byte got %h want %h", b, e); end
        end
        frame_starts.push_back(st);
      end
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    dmem_we = 1'b1; dmem_addr = a; dmem_wdata = d; dmem_wstrb = s;
    @(negedge clk);
    dmem_we = 1'b0; dmem_wstrb = 4'h0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    dmem_addr = a;
    #1;
    d = dmem_rdata;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (uart_tx !== 1'b1) begin n_err++; $display("FAIL rst_tx got %b want 1", uart_tx); end
    n_vec++; if (gpio_out !== 32'h0) begin n_err++; $display("FAIL rst_gpio got %h want 0", gpio_out); end
    n_vec++; if (timer_irq !== 1'b0) begin n_err++; $display("FAIL rst_irq got %b want 0", timer_irq); end
    rd(A_TIMER, r);
    n_vec++; if (r !== 32'h0) begin n_err++; $display("FAIL rst_timer got %h want 0", r); end
    rd(A_TIMECMP, r);
    n_vec++; if (r !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL rst_timecmp got %h want ffffffff", r); end
    rd(A_STATUS, r);
    n_vec++; if (r !== 32'h2) begin n_err++; $display("FAIL rst_status got %h want 2", r); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_ram();
    logic [31:0] r;
    wr(32'h100, 32'hAABB_CCDD, 4'b1111);
    wr(32'h100, 32'h1122_3344, 4'b0010);
    rd(32'h100, r);
    n_vec++; if (r !== 32'hAABB_33DD) begin n_err++; $display("FAIL ram_strobe got %h want aabb33dd", r); end
    rd(32'h102, r);
    n_vec++; if (r !== 32'hAABB_33DD) begin n_err++; $display("FAIL ram_lowbits got %h want aabb33dd", r); end
    rd(32'h1100, r);
    n_vec++; if (r !== 32'hAABB_33DD) begin n_err++; $display("FAIL ram_alias got %h want aabb33dd", r); end
    @(negedge clk);
    dmem_we = 1'b1; dmem_addr = 32'h100; dmem_wdata = 32'hDEAD_BEEF; dmem_wstrb = 4'hF;
    #1;
    n_vec++; if (dmem_rdata !== 32'hAABB_33DD) begin n_err++; $display("FAIL ram_rdw got %h want aabb33dd", dmem_rdata); end
    @(negedge clk);
    dmem_we = 1'b0; dmem_wstrb = 4'h0;
    rd(32'h100, r);
    n_vec++; if (r !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL ram_after_rdw got %h want deadbeef", r); end
    wr(32'h100, 32'h0, 4'b0000);
    wr(32'h104, 32'h1234_5678, 4'b1111);
    rd(32'h100, r);
    n_vec++; if (r !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL ram_nostrb got %h want deadbeef", r); end
    rd(32'h104, r);
    n_vec++; if (r !== 32'h1234_5678) begin n_err++; $display("FAIL ram_next got %h want 12345678", r); end
    @(negedge clk);
  endtask

  task automatic test_gpio();
    logic [31:0] r;
    wr(A_GPIO, 32'h1234_5678, 4'b1111);
    n_vec++; if (gpio_out !== 32'h1234_5678) begin n_err++; $display("FAIL gpio_full got %h want 12345678", gpio_out); end
    wr(A_GPIO, 32'hFF00_00AA, 4'b1001);
    n_vec++; if (gpio_out !== 32'hFF34_56AA) begin n_err++; $display("FAIL gpio_strb got %h want ff3456aa", gpio_out); end
    rd(A_GPIO, r);
    n_vec++; if (r !== 32'hFF34_56AA) begin n_err++; $display("FAIL gpio_read got %h want ff3456aa", r); end
    rd(A_TXDATA, r);
    n_vec++; if (r !== 32'h0) begin n_err++; $display("FAIL txdata_read got %h want 0", r); end
    @(negedge clk);
  endtask

  task automatic test_timer();
    logic [31:0] r;
    logic [31:0] t_exp;
    wr(A_TIMER, 32'hFFFF_FFFE, 4'b1111);
    rd(A_TIMER, r);
    n_vec++; if (r !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL timer_load got %h want fffffffe", r); end
    @(negedge clk); rd(A_TIMER, r);
    n_vec++; if (r !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL timer_max got %h want ffffffff", r); end
    @(negedge clk); rd(A_TIMER, r);
    n_vec++; if (r !== 32'h0) begin n_err++; $display("FAIL timer_wrap got %h want 0", r); end
    wr(A_TIMECMP, 32'h5, 4'b1111);
    t_exp = 32'h1;
    for (int k = 0; k < 7; k++) begin
      rd(A_TIMER, r);
      n_vec++; if (r !== t_exp) begin n_err++; $display("FAIL timer_count got %h want %h", r, t_exp); end
      n_vec++; if (timer_irq !== (t_exp >= 32'h5)) begin
        n_err++; $display("FAIL timer_irq got %b want %b at %h", timer_irq, (t_exp >= 32'h5), t_exp);
      end
      @(negedge clk);
      t_exp = t_exp + 32'h1;
    end
    wr(A_TIMECMP, 32'hFFFF_FFFF, 4'b1111);
    n_vec++; if (timer_irq !== 1'b0) begin n_err++; $display("FAIL timer_irq_clr got %b want 0", timer_irq); end
  endtask

  task automatic test_uart_frame();
    logic [31:0] r;
    logic [7:0]  pat;
    logic        e;
    pat = 8'h55;
    exp_q.push_back(pat);
    wr(A_TXDATA, {24'h0, pat}, 4'b0001);
    n_vec++; if (uart_tx !== 1'b1) begin n_err++; $display("FAIL frame_prepop got %b want 1", uart_tx); end
    @(negedge clk);
    for (int c = 0; c < 40; c++) begin
      if (c < 4)       e = 1'b0;
      else if (c < 36) e = pat[(c - 4) / 4];
      else             e = 1'b1;
      n_vec++; if (uart_tx !== e) begin n_err++; $display("FAIL frame_tx got %b want %b at cycle %0d", uart_tx, e, c); end
      rd(A_STATUS, r);
      n_vec++; if (r[2] !== 1'b1) begin n_err++; $display("FAIL frame_busy got %b want 1 at cycle %0d", r[2], c); end
      @(negedge clk);
    end
    rd(A_STATUS, r);
    n_vec++; if (r !== 32'h2) begin n_err++; $display("FAIL frame_done got %h want 2", r); end
    @(negedge clk);
  endtask

  task automatic test_fifo_overflow();
    logic [31:0] r;
    int k;
    frame_starts.delete();
    for (int b = 1; b <= 10; b++) begin
      if (b <= 9) exp_q.push_back(8'(b));
      wr(A_TXDATA, 32'(b), 4'b0001);
    end
    rd(A_STATUS, r);
    n_vec++; if (r !== 32'hD) begin n_err++; $display("FAIL ovf_status got %h want d", r); end
    wr(A_STATUS, 32'h8, 4'b0001);
    rd(A_STATUS, r);
    n_vec++; if (r !== 32'h5) begin n_err++; $display("FAIL ovf_clear got %h want 5", r); end
    k = 0;
    while (k < 600 && (exp_q.size() != 0 || r !== 32'h2)) begin
      @(negedge clk);
      rd(A_STATUS, r);
      k++;
    end
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL ovf_drain got %0d pending want 0", exp_q.size()); end
    n_vec++; if (r !== 32'h2) begin n_err++; $display("FAIL ovf_idle got %h want 2", r); end
    n_vec++; if (frame_starts.size() != 9) begin n_err++; $display("FAIL ovf_frames got %0d want 9", frame_starts.size()); end
    for (int i = 1; i < frame_starts.size(); i++) begin
      n_vec++;
      if (frame_starts[i] - frame_starts[i-1] != 10 * BAUD) begin
        n_err++; $display("FAIL ovf_b2b got %0d want %0d", frame_starts[i] - frame_starts[i-1], 10 * BAUD);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    logic [31:0] r;
    int lows;
    mon_en = 1'b0;
    wr(A_GPIO, 32'h0000_CAFE, 4'b1111);
    wr(A_TXDATA, 32'hA5, 4'b0001);
    repeat (10) @(negedge clk);
    n_vec++; if (uart_tx !== 1'b0) begin n_err++; $display("FAIL mid_bit1 got %b want 0", uart_tx); end
    rst = 1'b1;
    #1;
    n_vec++; if (uart_tx !== 1'b1) begin n_err++; $display("FAIL mid_rst_tx got %b want 1", uart_tx); end
    n_vec++; if (gpio_out !== 32'h0) begin n_err++; $display("FAIL mid_rst_gpio got %h want 0", gpio_out); end
    rd(A_STATUS, r);
    n_vec++; if (r !== 32'h2) begin n_err++; $display("FAIL mid_rst_status got %h want 2", r); end
    rd(A_TIMER, r);
    n_vec++; if (r !== 32'h0) begin n_err++; $display("FAIL mid_rst_timer got %h want 0", r); end
    @(negedge clk);
    rst = 1'b0;
    lows = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    n_vec++; if (lows != 0) begin n_err++; $display("FAIL mid_no_resume got %0d low cycles want 0", lows); end
    rd(A_STATUS, r);
    n_vec++; if (r !== 32'h2) begin n_err++; $display("FAIL mid_after_status got %h want 2", r); end
    mon_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unmapped();
    logic [31:0] r;
    wr(A_GPIO, 32'h5A5A_5A5A, 4'b1111);
    wr(A_TIMECMP, 32'h89AB_CDEF, 4'b1111);
    wr(32'h18, 32'h0BAD_F00D, 4'b1111);
    wr(A_TIMER, 32'h1000, 4'b1111);
    rd(A_UNMAP, r);
    n_vec++; if (r !== 32'h0) begin n_err++; $display("FAIL unmap_read got %h want 0", r); end
    wr(A_UNMAP, 32'hFFFF_FFFF, 4'b1111);
    rd(A_TIMER, r);
    n_vec++; if (r !== 32'h1001) begin n_err++; $display("FAIL unmap_timer got %h want 1001", r); end
    rd(A_TIMECMP, r);
    n_vec++; if (r !== 32'h89AB_CDEF) begin n_err++; $display("FAIL unmap_timecmp got %h want 89abcdef", r); end
    rd(A_STATUS, r);
    n_vec++; if (r !== 32'h2) begin n_err++; $display("FAIL unmap_status got %h want 2", r); end
    n_vec++; if (gpio_out !== 32'h5A5A_5A5A) begin n_err++; $display("FAIL unmap_gpio got %h want 5a5a5a5a", gpio_out); end
    dmem_addr = A_STATUS;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      #1;
      n_vec++; if (dmem_rdata !== 32'h2) begin n_err++; $display("FAIL hold_status got %h want 2 at %0d", dmem_rdata, c); end
    end
    rd(A_TIMER, r);
    n_vec++; if (r !== 32'h1065) begin n_err++; $display("FAIL hold_timer got %h want 1065", r); end
    rd(32'h18, r);
    n_vec++; if (r !== 32'h0BAD_F00D) begin n_err++; $display("FAIL unmap_ram got %h want 0badf00d", r); end
    n_vec++; if (gpio_out !== 32'h5A5A_5A5A) begin n_err++; $display("FAIL hold_gpio got %h want 5a5a5a5a", gpio_out); end
    n_vec++; if (uart_tx !== 1'b1) begin n_err++; $display("FAIL hold_tx got %b want 1", uart_tx); end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_ram();
    test_gpio();
    test_timer();
    test_uart_frame();
    test_fifo_overflow();
    test_reset_midframe();
    test_unmapped();
    n_vec++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL final_scoreboard got %0d pending want 0", exp_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/riscv5_dmem_resp.md
Name: riscv5_dmem_resp

Overview:
Data-memory responder for the riscv5 pipeline's dmem port, the target side of its store/load traffic. It holds a byte-strobed word RAM and an MMIO page with GPIO, a free-running timer with compare interrupt, and a FIFO-buffered 8N1 UART transmitter.
The initiator presents an address every cycle with no read strobe. It samples read data at the same clock edge. Reads are therefore combinational and have no side effects.

Parameters:
RAM_AW, 10, log2 of RAM depth in 32-bit words (1024 words = 4 KiB)
BAUD_DIV, 868, clocks per UART bit (>=2)
FIFO_AW, 3, log2 of TX FIFO depth (8 entries)

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
dmem_we  input  1  write request this cycle
dmem_wstrb  input  4  byte enables; bit n = byte lane n
dmem_addr  input  32  byte address; bits [1:0] ignored
dmem_wdata  input  32  write data
dmem_rdata  output  32  read data, combinational from dmem_addr
gpio_out  output  32  GPIO register
timer_irq  output  1  high while TIMER >= TIMECMP (unsigned)
uart_tx  output  1  serial line, idle high

Behaviour:
- Decode:
  - addr[31]=0 selects RAM, word index addr[RAM_AW+1:2]; the region aliases.
  - addr[31]=1 selects MMIO by addr[4:2]. Unlisted offsets read 0; writes to them are ignored.
- MMIO map (offsets from 0x8000_0000):
  - 0x00 GPIO_OUT RW
  - 0x04 TIMER RW
  - 0x08 TIMECMP RW
  - 0x0C UART_TXDATA WO, reads 0
  - 0x10 UART_STATUS: bit0 full, bit1 empty, bit2 busy, bit3 overflow (sticky, write-1-to-clear); other bits read 0
- Writes: committed at the rising edge when dmem_we=1, and only to lanes with wstrb set. wstrb=0 with we=1 is a no-op.
- Read-during-write to the same address: dmem_rdata shows pre-edge content. The new value is visible the cycle after.
- Reset values:
  - dmem_rdata follows decode of register state.
  - gpio_out=0, TIMER=0, TIMECMP=0xFFFF_FFFF, timer_irq=0, uart_tx=1.
  - FIFO empty, overflow=0, UART FSM IDLE.
  - RAM contents are not reset.
  - Reset asserted mid-frame aborts the frame; uart_tx goes high immediately.
- TIMER:
  - Increments by 1 every cycle and wraps 0xFFFF_FFFF to 0.
  - A write cycle loads the strobed bytes; unstrobed bytes keep their pre-edge value. No increment that cycle.
- timer_irq: combinational compare of the TIMER and TIMECMP registers.
- UART_TXDATA write:
  - With wstrb[0]=1, pushes wdata[7:0] if the FIFO was not full before the edge.
  - If it was full, the byte is dropped and overflow is set.
  - wstrb[0]=0 does nothing.
  - A push and a pop in the same cycle are both honoured (count unchanged).
- UART_STATUS write: wdata[3]=1 with wstrb[0]=1 clears overflow. If an overflow occurs the same cycle, set wins.
- UART FSM, states IDLE, START, DATA, STOP:
  - IDLE: at an edge with the FIFO non-empty, pop into the shift register and go to START.
  - START: uart_tx=0 for BAUD_DIV cycles.
  - DATA: 8 bits, LSB first, BAUD_DIV cycles each, 3-bit bit counter.
  - STOP: uart_tx=1 for BAUD_DIV cycles. Then pop and go to START directly if the FIFO is non-empty (no idle gap), else go to IDLE.
  - Frame length is exactly 10*BAUD_DIV cycles.
  - busy=1 in every state except IDLE.
  - uart_tx is registered, and its first low cycle is the cycle after the pop edge.
- Widths:
  - Baud counter width is clog2(BAUD_DIV).
  - FIFO uses pointers of FIFO_AW+1 bits; full/empty are derived from pointer MSB compare.

Decomposition:
- Package riscv5_pkg holds:
  - MMIO_BASE and the register offset constants
  - UART_STATUS bit indices
  - the UART FSM state enum (2-bit)
- Sub-module riscv5_uart_tx contains the FIFO and serializer. Its ports: push, push_data[7:0], clr_ovf, full, empty, busy, overflow, tx.
- The top level keeps decode, RAM, GPIO and timer.

Test Plan:
1. RAM strobes: write 0xAABBCCDD to 0x100 with wstrb=1111, then 0x11223344 with wstrb=0010. Reading 0x100 returns 0xAABB33DD, and reading 0x102 returns the same word.
2. Timer wrap:
   - Write TIMER=0xFFFF_FFFE; the following three cycles read 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000.
   - Then write TIMECMP=5; timer_irq rises in the cycle TIMER reads 5.
3. UART frame: BAUD_DIV=4, write 0x55 to TXDATA. uart_tx shows:
   - 0 for 4 cycles
   - then 1,0,1,0,1,0,1,0, 4 cycles each
   - then 1 for 4 cycles
   busy=1 throughout the 40 cycles, then busy=0 and empty=1.
4. FIFO overflow: BAUD_DIV=4, write bytes 1..10 on 10 consecutive cycles.
   - Byte 1 goes to the serializer, bytes 2..9 are buffered, and byte 10 is dropped.
   - STATUS reads 0x0D (full, busy, overflow).
   - Writing 0x8 to STATUS clears overflow.
   - Exactly bytes 1..9 are emitted, back-to-back, in order.
5. Reset mid-frame: assert rst during DATA. uart_tx=1, STATUS=0x02, gpio_out=0 and TIMER=0 immediately. The aborted byte is never resumed.
6. Unmapped and side-effect-free reads:
   - Reading 0x8000_0018 returns 0; writing it leaves every register unchanged.
   - Holding dmem_addr at 0x8000_0010 for 100 cycles with we=0 changes no state.
